// File: rtl/snow64_sliced_data_gatherer.sv
// Packs a stream of 8/16/32/64-bit scalar elements into one 64-bit sliced word.
// Lane k of element width W lands in bits [(k+1)*W-1 : k*W]; unused lanes read as zero.
//
// accumulator | meaning
// EMPTY       | acc_cnt == 0, next accepted element starts lane 0 and sets acc_size
// FILLING     | acc_cnt != 0, only elements of acc_size are accepted
module snow64_sliced_data_gatherer #(
    parameter int WIDTH__DATA = 64,
    parameter int WIDTH__SIZE = 2,
    parameter int NUM_BYTES   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH__SIZE-1:0] in_size,
    input  logic [WIDTH__DATA-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH__DATA-1:0] out_data,
    output logic [WIDTH__SIZE-1:0] out_size,
    output logic [NUM_BYTES-1:0]   out_lane_mask
);

    logic [3:0]             acc_cnt;
    logic [WIDTH__DATA-1:0] acc_data;
    logic [NUM_BYTES-1:0]   acc_mask;
    logic [WIDTH__SIZE-1:0] acc_size;

    logic                   slot_free;
    logic                   mismatch;
    logic                   accept;
    logic                   flush;
    logic                   complete;
    logic [3:0]             lanes;
    logic [2:0]             byte_off;
    logic [WIDTH__DATA-1:0] elem;
    logic [NUM_BYTES-1:0]   elem_mask;
    logic [WIDTH__DATA-1:0] merged_data;
    logic [NUM_BYTES-1:0]   merged_mask;

    assign slot_free = !out_valid || out_ready;
    assign mismatch  = (acc_cnt != 4'd0) && in_valid && (in_size != acc_size);
    assign in_ready  = slot_free && !mismatch;
    assign accept    = in_valid && in_ready;
    // A size change closes the partial word early, but only when the output slot can take it.
    assign flush     = slot_free && mismatch;

    assign lanes    = 4'd8 >> in_size;
    assign byte_off = acc_cnt[2:0] << in_size;
    assign complete = accept && ((acc_cnt + 4'd1 == lanes) || in_last);

    always_comb begin
        elem      = '0;
        elem_mask = '0;
        case (in_size)
            2'd0: begin
                elem      = {56'd0, in_data[7:0]};
                elem_mask = 8'h01;
            end
            2'd1: begin
                elem      = {48'd0, in_data[15:0]};
                elem_mask = 8'h03;
            end
            2'd2: begin
                elem      = {32'd0, in_data[31:0]};
                elem_mask = 8'h0F;
            end
            default: begin
                elem      = in_data;
                elem_mask = 8'hFF;
            end
        endcase
    end

    assign merged_data = acc_data | (elem << {byte_off, 3'b000});
    assign merged_mask = acc_mask | (elem_mask << byte_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt       <= '0;
            acc_data      <= '0;
            acc_mask      <= '0;
            acc_size      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_size      <= '0;
            out_lane_mask <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (complete) begin
                out_data      <= merged_data;
                out_size      <= in_size;
                out_lane_mask <= merged_mask;
                out_valid     <= 1'b1;
                acc_cnt       <= '0;
                acc_data      <= '0;
                acc_mask      <= '0;
                acc_size      <= '0;
            end else if (accept) begin
                acc_data <= merged_data;
                acc_mask <= merged_mask;
                acc_size <= in_size;
                acc_cnt  <= acc_cnt + 4'd1;
            end else if (flush) begin
                out_data      <= acc_data;
                out_size      <= acc_size;
                out_lane_mask <= acc_mask;
                out_valid     <= 1'b1;
                acc_cnt       <= '0;
                acc_data      <= '0;
                acc_mask      <= '0;
                acc_size      <= '0;
            end
        end
    end

endmodule
